// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-master RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  typedef logic owner_t;

  localparam owner_t M0 = 1'b0;
  localparam owner_t M1 = 1'b1;

  localparam int MAX_OUTST_DEF = 2;

endpackage : ram_arb_pkg

`default_nettype wire

// File: rtl/ram_arb_owner_fifo.sv
// ============================================================================
// Module      : ram_arb_owner_fifo
// Description : Owner-ID FIFO tracking which master owns each outstanding access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_owner_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  owner_t        push_owner_i,
  input  logic          pop_i,
  output owner_t        head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  owner_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_ok  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_owner_i;
  end

endmodule : ram_arb_owner_fifo

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Two-master arbiter onto one pipelined RAM port with response
//               routing. Define RAM_ARB_ROUND_ROBIN_EN for round-robin
//               conflict resolution; otherwise master 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              s_req_o,
  input  logic              s_gnt_i,
  input  logic              s_rvalid_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_we_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              err_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  owner_t        fifo_head;
  logic          unused_full;

  logic [1:0]    req_eff;
  owner_t        sel;
  owner_t        conflict_winner;
  logic          room;
  logic          hs;
  logic          pop;
  logic          lock_q, lock_d;
  owner_t        lock_own_q, lock_own_d;
  logic          err_q, err_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  owner_t last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_grant_q <= M1;
    else if (hs) last_grant_q <= sel;
  end

  assign conflict_winner = (last_grant_q == M0) ? M1 : M0;
`else
  assign conflict_winner = M0;
`endif

  always_comb begin
    req_eff = {m1_req_i, m0_req_i};
    // A locked master hides the other one until its handshake completes.
    if (lock_q) req_eff = (lock_own_q == M1) ? {m1_req_i, 1'b0} : {1'b0, m0_req_i};
    case (req_eff)
      2'b10:   sel = M1;
      2'b11:   sel = conflict_winner;
      default: sel = M0;
    endcase
  end

  assign room    = (fifo_count < CW'(MAX_OUTST)) | s_rvalid_i;
  assign s_req_o = (|req_eff) & room;
  assign hs      = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & ~fifo_empty;

  always_comb begin
    lock_d     = 1'b0;
    lock_own_d = lock_own_q;
    err_d      = err_q | (s_rvalid_i & fifo_empty);
    if (lock_q) begin
      lock_d = req_eff[lock_own_q] & ~hs;
    end else begin
      lock_d     = s_req_o & ~s_gnt_i;
      lock_own_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_own_q <= M0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      err_q      <= err_d;
    end
  end

  ram_arb_owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (hs),
    .push_owner_i (sel),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign unused_full = fifo_full;

  assign s_addr_o  = !s_req_o ? '0 : (sel == M1) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = !s_req_o ? '0 : (sel == M1) ? m1_we_i    : m0_we_i;
  assign s_wdata_o = !s_req_o ? '0 : (sel == M1) ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o    = hs & (sel == M0);
  assign m1_gnt_o    = hs & (sel == M1);
  assign m0_rvalid_o = pop & (fifo_head == M0);
  assign m1_rvalid_o = pop & (fifo_head == M1);
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
  assign err_o       = err_q;

endmodule : ram_port_arbiter

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter (directed table,
//               reset sequence, randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam logic [AW-1:0] A0 = 32'h4;
  localparam logic [AW-1:0] A1 = 32'h8;
  localparam logic [DW-1:0] D0 = 32'h0000_D000;
  localparam logic [DW-1:0] D1 = 32'h0000_D111;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i;
  logic m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o, s_wdata_o, s_rdata_i;
  logic s_req_o, s_gnt_i, s_rvalid_i, s_we_o, err_o;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
    .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic sreq, input logic [AW-1:0] addr,
                         input logic we, input logic [DW-1:0] wd, input logic [1:0] gnt,
                         input logic [1:0] rv, input logic err);
    chk({tag, "/s_req"},   64'(s_req_o),   64'(sreq));
    chk({tag, "/s_addr"},  64'(s_addr_o),  64'(addr));
    chk({tag, "/s_we"},    64'(s_we_o),    64'(we));
    chk({tag, "/s_wdata"}, 64'(s_wdata_o), 64'(wd));
    chk({tag, "/gnt"},     64'({m1_gnt_o, m0_gnt_o}),       64'(gnt));
    chk({tag, "/rvalid"},  64'({m1_rvalid_o, m0_rvalid_o}), 64'(rv));
    chk({tag, "/rdata0"},  64'(m0_rdata_o), 64'(rv[0] ? s_rdata_i : '0));
    chk({tag, "/rdata1"},  64'(m1_rdata_o), 64'(rv[1] ? s_rdata_i : '0));
    chk({tag, "/err"},     64'(err_o),     64'(err));
  endtask

  // {r0, r1, gnt, rvalid} -> {s_req, sel_rr, sel_fixed, rv_rr{m1,m0}, rv_fixed{m1,m0}, err}
  typedef struct packed {
    logic r0, r1, gnt, rv;
    logic sreq, sel_rr, sel_fx;
    logic [1:0] rv_rr, rv_fx;
    logic err;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // Reference model state
  bit q[$];
  bit lk, lko, last, merr;

  logic sel, sreq, e0, e1;
  logic [1:0] rv;
  logic [AW-1:0] xaddr;

  task automatic idle_inputs();
    m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0;
    m0_addr_i = A0; m1_addr_i = A1; m0_we_i = 0; m1_we_i = 1;
    m0_wdata_i = D0; m1_wdata_i = D1; s_rdata_i = 32'hCAFE_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    tbl[0]  = 12'b0000_000_00_00_0;
    tbl[1]  = 12'b1110_100_00_00_0;
    tbl[2]  = 12'b1111_110_01_01_0;
    tbl[3]  = 12'b1111_100_10_01_0;
    tbl[4]  = 12'b1111_110_01_01_0;
    tbl[5]  = 12'b1111_100_10_01_0;
    tbl[6]  = 12'b1111_110_01_01_0;
    tbl[7]  = 12'b0011_000_10_01_0;
    tbl[8]  = 12'b1010_100_00_00_0;
    tbl[9]  = 12'b0011_000_01_01_0;
    tbl[10] = 12'b0100_111_00_00_0;
    tbl[11] = 12'b1100_111_00_00_0;
    tbl[12] = 12'b1100_111_00_00_0;
    tbl[13] = 12'b1110_111_00_00_0;
    tbl[14] = 12'b1010_100_00_00_0;
    tbl[15] = 12'b1110_000_00_00_0;
    tbl[16] = 12'b1111_110_10_10_0;
    tbl[17] = 12'b0011_000_01_01_0;
    tbl[18] = 12'b0011_000_10_01_0;
    tbl[19] = 12'b0001_000_00_00_0;
    tbl[20] = 12'b0000_000_00_00_1;
    tbl[21] = 12'b1010_100_00_00_1;

    // Reset state, with a stray rvalid present while reset is held
    idle_inputs();
    rst_n = 0;
    s_rvalid_i = 1;
    repeat (2) @(posedge clk);
    #2 chk_all("reset", 0, '0, 0, '0, 2'b00, 2'b00, 0);
    s_rvalid_i = 0;
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      logic s;
      logic [1:0] r;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      s = tbl[i].sel_rr; r = tbl[i].rv_rr;
`else
      s = tbl[i].sel_fx; r = tbl[i].rv_fx;
`endif
      m0_req_i = tbl[i].r0; m1_req_i = tbl[i].r1;
      s_gnt_i = tbl[i].gnt; s_rvalid_i = tbl[i].rv;
      s_rdata_i = 32'hA5A5_0000 | 32'(i);
      #2;
      chk_all($sformatf("vec%0d", i), tbl[i].sreq,
              tbl[i].sreq ? (s ? A1 : A0) : '0,
              tbl[i].sreq ? s : 1'b0,
              tbl[i].sreq ? (s ? D1 : D0) : '0,
              (tbl[i].sreq & tbl[i].gnt) ? (s ? 2'b10 : 2'b01) : 2'b00,
              r, tbl[i].err);
      @(posedge clk); #1;
    end

    // Reset mid-transaction: one access outstanding, err set
    idle_inputs();
    s_rvalid_i = 1;
    #1 rst_n = 0;
    #1 chk_all("rst_mid", 0, '0, 0, '0, 2'b00, 2'b00, 0);
    @(posedge clk); #1;
    s_rvalid_i = 0;
    rst_n = 1;
    #1 chk_all("rst_rel", 0, '0, 0, '0, 2'b00, 2'b00, 0);
    @(posedge clk); #1;
    s_rvalid_i = 1;
    #1 chk_all("lost_rv", 0, '0, 0, '0, 2'b00, 2'b00, 0);
    @(posedge clk); #1;
    s_rvalid_i = 0;
    #1 chk_all("lost_err", 0, '0, 0, '0, 2'b00, 2'b00, 1);

    // Randomized traffic against the reference model
    do_reset();
    q.delete(); lk = 0; lko = 0; last = 1; merr = 0;
    for (int c = 0; c < 600; c++) begin
      m0_req_i   = ($urandom_range(0, 9) < 7);
      m1_req_i   = ($urandom_range(0, 9) < 7);
      m0_addr_i  = $urandom; m1_addr_i = $urandom;
      m0_we_i    = $urandom_range(0, 1); m1_we_i = $urandom_range(0, 1);
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      s_gnt_i    = ($urandom_range(0, 9) < 6);
      s_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 2);
      s_rdata_i  = $urandom;
      #2;
      e0 = m0_req_i && !(lk && lko);
      e1 = m1_req_i && !(lk && !lko);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      sel = (e0 && e1) ? !last : e1;
`else
      sel = (e0 && e1) ? 1'b0 : e1;
`endif
      sreq  = (e0 || e1) && (q.size() < MO || s_rvalid_i);
      rv    = (s_rvalid_i && q.size() > 0) ? (q[0] ? 2'b10 : 2'b01) : 2'b00;
      xaddr = sreq ? (sel ? m1_addr_i : m0_addr_i) : '0;
      chk_all($sformatf("rnd%0d", c), sreq, xaddr,
              sreq ? (sel ? m1_we_i : m0_we_i) : 1'b0,
              sreq ? (sel ? m1_wdata_i : m0_wdata_i) : '0,
              (sreq && s_gnt_i) ? (sel ? 2'b10 : 2'b01) : 2'b00,
              rv, merr);
      @(posedge clk);
      if (s_rvalid_i && q.size() > 0) void'(q.pop_front());
      else if (s_rvalid_i) merr = 1;
      if (sreq && s_gnt_i) begin
        q.push_back(sel);
        last = sel;
      end
      if (lk) lk = (lko ? m1_req_i : m0_req_i) && !(sreq && s_gnt_i);
      else begin
        lk  = sreq && !s_gnt_i;
        lko = sel;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_port_arbiter

`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, 32, address width; DATA_W, 32, data width; MAX_OUTST, 2, maximum number of accepted-but-unanswered transactions (power of two, at least 1).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all flops on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mK_req_i  in  1  master K request (K = 0, 1).
- mK_gnt_o  out  1  master K request accepted this cycle.
- mK_rvalid_o  out  1  master K response valid.
- mK_addr_i  in  ADDR_W  master K address.
- mK_we_i  in  1  master K write enable.
- mK_wdata_i  in  DATA_W  master K write data.
- mK_rdata_o  out  DATA_W  master K read data.
- s_req_o  out  1  request to the single memory port.
- s_gnt_i  in  1  memory port accepted the request.
- s_rvalid_i  in  1  memory port response valid.
- s_addr_o  out  ADDR_W  address forwarded to the memory port.
- s_we_o  out  1  write enable forwarded to the memory port.
- s_wdata_o  out  DATA_W  write data forwarded to the memory port.
- s_rdata_i  in  DATA_W  read data returned by the memory port.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-003 The block SHALL drive s_req_o high when any mK_req_i is high and the outstanding count is below MAX_OUTST, or when the count equals MAX_OUTST and s_rvalid_i is high in the same cycle.
REQ-004 The block SHALL drive s_addr_o, s_we_o and s_wdata_o combinationally from the selected master, and SHALL drive them to 0 when s_req_o is low.
REQ-005 The block SHALL drive mK_gnt_o = s_req_o & s_gnt_i & (selected == K); at most one gnt SHALL be high in any cycle.
REQ-006 Selection when exactly one master requests: that master.
REQ-007 Selection when both masters request: the master not recorded in the last_grant flop wins.
REQ-008 last_grant SHALL update to the granted master on every accepted handshake (s_req_o & s_gnt_i).
REQ-009 If s_req_o is high and s_gnt_i is low, the block SHALL hold the current selection in a lock flop until the handshake is accepted.
REQ-010 While the lock is held, the block SHALL ignore requests from the other master; if the locked master drops its req, the lock SHALL clear in the next cycle.
REQ-011 On every accepted handshake, the block SHALL push the owner ID into an owner FIFO of depth MAX_OUTST.
REQ-012 On every s_rvalid_i, the block SHALL pop the owner FIFO and pulse mK_rvalid_o for the head owner in the same cycle.
REQ-013 A push and a pop in the same cycle SHALL leave the outstanding count unchanged.
REQ-014 Both mK_rdata_o SHALL be driven as s_rdata_i when that master's rvalid is high, and as 0 otherwise.
REQ-015 Write transactions SHALL also occupy a FIFO slot and receive an rvalid.
REQ-016 The FIFO read and write pointers SHALL wrap modulo MAX_OUTST.
REQ-017 With MAX_OUTST = 2 and a memory that grants immediately and returns rvalid one cycle later, the block SHALL sustain one accepted transaction per cycle.
REQ-018 If s_rvalid_i is high while the FIFO is empty, the block SHALL set err_o, assert no mK_rvalid_o and leave the pointers unchanged.
REQ-019 err_o SHALL clear only on reset.

Reset
REQ-020 While rst_n is low, the following SHALL be forced and held: FIFO empty, count = 0, lock clear, last_grant = 1 (master 0 wins the first conflict), err_o = 0.
REQ-021 While rst_n is low, all mK_rvalid_o SHALL be 0.
REQ-022 When reset is asserted mid-transaction, the block SHALL discard all outstanding entries; a subsequent s_rvalid_i arriving after reset release with an empty FIFO SHALL set err_o.

Configuration
REQ-023 The macro RAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 With RAM_ARB_ROUND_ROBIN_EN defined, the block SHALL arbitrate per REQ-007/REQ-008.
REQ-025 Without RAM_ARB_ROUND_ROBIN_EN, master 0 SHALL always win a conflict, the last_grant flop SHALL not be built, and the lock rule (REQ-009) SHALL still apply.

Structure
REQ-026 A shared package ram_arb_pkg SHALL hold the owner-ID typedef (1 bit), the master-index constants M0 = 0 and M1 = 1, and the MAX_OUTST default.
REQ-027 The owner FIFO SHALL be a sub-module named ram_arb_owner_fifo (parameterised depth, push, pop, full, empty and count outputs).

Verification
REQ-028 Scenario: m0 issues a read of address 0x4 alone, with the memory granting immediately -> m0_gnt_o high in cycle N, m0_rvalid_o high in cycle N+1 with m0_rdata_o = mem[4], m1_rvalid_o stays 0.
REQ-029 Scenario: both masters request continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1 and rvalids follow in the same order one cycle later; without RAM_ARB_ROUND_ROBIN_EN, grants are 0,0,0,0,0,0.
REQ-030 Scenario: s_gnt_i held low for 3 cycles while m1 is locked and m0 raises req in the 2nd cycle -> s_addr_o remains m1's address; m1 receives the first gnt; m0 is granted next.
REQ-031 Scenario: the memory withholds rvalid with 2 transactions outstanding -> s_req_o stays 0; on the rvalid cycle, a new grant is accepted simultaneously and the count stays 2.
REQ-032 Scenario: a spurious s_rvalid_i pulse with an empty FIFO -> err_o goes high and stays high; no mK_rvalid_o is asserted; err_o clears on rst_n low.
REQ-033 Scenario: rst_n asserted with 1 transaction outstanding -> the count returns to 0 and no mK_rvalid_o is asserted for the lost transaction.
